// File: rtl/count_sched_pkg.sv
// Shared types, defaults and helpers for the count slot scheduler.
// Contents: sched_state_t FSM encoding, default parameter values,
// rr_pick (rotating-priority one-hot pick) and oh_index (one-hot to index).
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_MAX_COUNT = 3;
  localparam int unsigned MAX_REQ       = 8;
  localparam int unsigned IDX_W         = 3;

  // First set bit of req searching from ptr upward, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] win;
    logic [IDX_W-1:0]   idx;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = IDX_W'((32'(ptr) + i) % n);
      if ((i < n) && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] oh_index(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter 0..MAX with synchronous clear.
// Ports: clk, resetn (async active-low), clear (to 0, has priority),
//        enable (+1, holds at MAX), count (registered value),
//        at_max (registered, high when count >= MAX).
module sat_counter #(
  parameter int unsigned MAX = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         enable,
  output logic [$clog2(MAX+1)-1:0]     count,
  output logic                         at_max
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] count_d;

  // Next value: clear wins, otherwise saturating increment.
  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count >= W'(MAX)) count_d = W'(MAX);
      else                  count_d = count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      at_max <= 1'b0;
    end else begin
      count  <= count_d;
      at_max <= (count_d >= W'(MAX));
    end
  end

endmodule

// File: rtl/count_slot_scheduler.sv
// Round-robin scheduler sharing one saturating counter among requesters.
// Each winner owns the counter for one slot (0..MAX_COUNT), then releases it.
// Ports: clk, resetn (async active-low), req_valid[NUM_REQ] (held until
//        req_ready), req_ready (one-hot accept pulse), grant (one-hot owner),
//        count (slot count), done (slot-end pulse), busy (RUN or DONE).
// Optional: define COUNT_SLOT_SCHED_ABORT_EN to add the abort input, which
//        ends a RUN slot early without a done pulse.
module count_slot_scheduler
  import count_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic                               clk,
  input  logic                               resetn,
`ifdef COUNT_SLOT_SCHED_ABORT_EN
  input  logic                               abort,
`endif
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 grant,
  output logic [$clog2(MAX_COUNT+1)-1:0]     count,
  output logic                               done,
  output logic                               busy
);

  localparam int unsigned COUNT_W = $clog2(MAX_COUNT + 1);
  localparam int unsigned PTR_W   = $clog2(NUM_REQ);

  sched_state_t state, state_n;

  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   owner, owner_d;
  logic [PTR_W-1:0]   next_ptr_c;
  logic [NUM_REQ-1:0] pick_c;
  logic [NUM_REQ-1:0] grant_d, req_ready_d;
  logic               done_d;
  logic               cnt_clr, cnt_en, at_max;
  logic               terminal_c, abort_c;

`ifdef COUNT_SLOT_SCHED_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign pick_c     = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), IDX_W'(rr_ptr), NUM_REQ));
  // at_max covers any out-of-range count so the slot always terminates.
  assign terminal_c = (count == COUNT_W'(MAX_COUNT - 1)) || at_max;
  assign next_ptr_c = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

  sat_counter #(.MAX(MAX_COUNT)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (count),
    .at_max (at_max)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (|req_valid) state_n = RUN;
      RUN: begin
        if (abort_c)         state_n = IDLE;
        else if (terminal_c) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output / datapath control (next values of the registered outputs).
  always_comb begin
    grant_d     = grant;
    req_ready_d = '0;
    done_d      = 1'b0;
    rr_ptr_d    = rr_ptr;
    owner_d     = owner;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state)
      IDLE: begin
        grant_d = '0;
        cnt_clr = 1'b1;
        if (|req_valid) begin
          grant_d     = pick_c;
          req_ready_d = pick_c;
          owner_d     = PTR_W'(oh_index(MAX_REQ'(pick_c)));
        end
      end
      RUN: begin
        if (abort_c) begin
          grant_d  = '0;
          cnt_clr  = 1'b1;
          rr_ptr_d = next_ptr_c;
        end else begin
          cnt_en = 1'b1;
          done_d = terminal_c;
        end
      end
      DONE: begin
        grant_d  = '0;
        cnt_clr  = 1'b1;
        rr_ptr_d = next_ptr_c;
      end
      default: begin
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant     <= '0;
      req_ready <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
    end else begin
      grant     <= grant_d;
      req_ready <= req_ready_d;
      done      <= done_d;
      busy      <= (state_n != IDLE);
      rr_ptr    <= rr_ptr_d;
      owner     <= owner_d;
    end
  end

endmodule

// File: tb/tb_count_slot_scheduler.sv
// Directed self-checking bench for count_slot_scheduler (NUM_REQ=4, MAX_COUNT=3).
// Abort scenario is included when COUNT_SLOT_SCHED_ABORT_EN is defined.
module tb_count_slot_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] grant;
  logic [1:0] count;
  logic       done;
  logic       busy;
`ifdef COUNT_SLOT_SCHED_ABORT_EN
  logic       abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  count_slot_scheduler #(.NUM_REQ(4), .MAX_COUNT(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
`ifdef COUNT_SLOT_SCHED_ABORT_EN
    .abort     (abort),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .grant     (grant),
    .count     (count),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    tick();
    chk("idle_grant", 32'(grant), 0);

    // Single request from requester 0.
    req_valid = 4'b0001;
    tick();
    chk("s_grant", 32'(grant), 32'h1);
    chk("s_ready", 32'(req_ready), 32'h1);
    chk("s_count0", 32'(count), 0);
    chk("s_busy", 32'(busy), 1);
    req_valid = 4'b0000;
    tick();
    chk("s_count1", 32'(count), 1);
    chk("s_ready_pulse", 32'(req_ready), 0);
    chk("s_done_early", 32'(done), 0);
    tick();
    chk("s_count2", 32'(count), 2);
    tick();
    chk("s_count3", 32'(count), 3);
    chk("s_done", 32'(done), 1);
    chk("s_busy_done", 32'(busy), 1);
    tick();
    chk("s_end_grant", 32'(grant), 0);
    chk("s_end_count", 32'(count), 0);
    chk("s_end_done", 32'(done), 0);
    chk("s_end_busy", 32'(busy), 0);

    // rr_ptr now 1: 0011 grants requester 1 first, then 0.
    req_valid = 4'b0011;
    tick();
    chk("rr_grant1", 32'(grant), 32'h2);
    chk("rr_ready1", 32'(req_ready), 32'h2);
    repeat (4) tick();
    chk("rr_gap", 32'(grant), 0);
    tick();
    chk("rr_grant0", 32'(grant), 32'h1);
    chk("rr_ready0", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    repeat (3) tick();
    chk("rr_done", 32'(done), 1);
    tick();

    // rr_ptr now 1: requester 3 alone, reset at count=2.
    req_valid = 4'b1000;
    tick();
    chk("r_grant", 32'(grant), 32'h8);
    req_valid = 4'b0000;
    repeat (2) tick();
    chk("r_count2", 32'(count), 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("r_async_grant", 32'(grant), 0);
    chk("r_async_count", 32'(count), 0);
    chk("r_async_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("r_no_done", 32'(done), 0);
    resetn = 1'b1;

    // All requesting: rr_ptr back at 0 after reset.
    req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("all_grant", 32'(grant), 32'(1 << (s % 4)));
      chk("all_ready", 32'(req_ready), 32'(1 << (s % 4)));
      chk("all_count0", 32'(count), 0);
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk("all_count", 32'(count), 32'(k));
        chk("all_done", 32'(done), (k == 3) ? 32'h1 : 32'h0);
        chk("all_ready_lo", 32'(req_ready), 0);
      end
      tick();
      chk("all_gap", 32'(grant), 0);
      chk("all_gap_count", 32'(count), 0);
      if (s == 4) req_valid = 4'b0000;
    end

    // rr_ptr now 1: requester 2 pulses req_valid only during RUN.
    req_valid = 4'b0001;
    tick();
    chk("w_grant", 32'(grant), 32'h1);
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      chk("w_ready", 32'(req_ready), 0);
      tick();
    end
    chk("w_idle_grant", 32'(grant), 0);

`ifdef COUNT_SLOT_SCHED_ABORT_EN
    // rr_ptr now 1: abort requester 1 at count=1, next grant goes to 2.
    req_valid = 4'b0110;
    tick();
    chk("a_grant", 32'(grant), 32'h2);
    tick();
    chk("a_count1", 32'(count), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_grant_clr", 32'(grant), 0);
    chk("a_count_clr", 32'(count), 0);
    chk("a_no_done", 32'(done), 0);
    chk("a_busy", 32'(busy), 0);
    tick();
    chk("a_next", 32'(grant), 32'h4);
    req_valid = 4'b0000;
    repeat (4) tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
